// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-side inputs and MEM/redirect/exception outputs of the EX/MEM stage
interface ex_mem_stage_if;
    logic        ex_valid;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        WriteEnable;
    logic        OverFlow;
    logic        JrSel;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_branch_target;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_write_reg;
    logic [31:0] ex_store_data;
    logic        mem_stall;
    logic        exc_ack;

    logic        ex_ready;
    logic        mem_valid;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_mem_to_reg;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_write_reg;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_upstream;
    logic        exc_pending;
    logic [31:0] epc;
    logic [31:0] cause;

    modport slave (
        input  ex_valid, ALUResult, Zero, WriteEnable, OverFlow, JrSel, ex_is_branch,
               ex_pc, ex_branch_target, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_write_reg, ex_store_data, mem_stall, exc_ack,
        output ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_mem_to_reg, mem_alu_result, mem_store_data, mem_write_reg,
               redirect_valid, redirect_pc, flush_upstream, exc_pending, epc, cause
    );

    modport master (
        output ex_valid, ALUResult, Zero, WriteEnable, OverFlow, JrSel, ex_is_branch,
               ex_pc, ex_branch_target, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_write_reg, ex_store_data, mem_stall, exc_ack,
        input  ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_mem_to_reg, mem_alu_result, mem_store_data, mem_write_reg,
               redirect_valid, redirect_pc, flush_upstream, exc_pending, epc, cause
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch/jr redirect and overflow trap
// Optional precise overflow trap with EPC/Cause capture: define EX_MEM_OVF_TRAP_EN.
module ex_mem_stage #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input logic          Clk,
    input logic          Rst_n,
    ex_mem_stage_if.slave bus
);
    typedef enum logic {RUN, SQUASH} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        capture;
    logic        v;
    logic        trap;
    logic        redir;
    logic [31:0] redir_target;

    assign capture     = !bus.mem_stall;
    assign bus.ex_ready = capture;
    // In SQUASH the instruction in EX is on the wrong path and becomes a bubble.
    assign v = bus.ex_valid && (state_q == RUN);

`ifdef EX_MEM_OVF_TRAP_EN
    assign trap = v && bus.OverFlow;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        redir        = 1'b0;
        redir_target = 32'h0;
        if (trap) begin
            redir        = 1'b1;
            redir_target = EXC_VECTOR;
        end else if (v && bus.JrSel) begin
            redir        = 1'b1;
            redir_target = bus.ALUResult;
        end else if (v && bus.ex_is_branch && bus.Zero) begin
            redir        = 1'b1;
            redir_target = bus.ex_branch_target;
        end
    end

    always_comb begin
        state_d = state_q;
        if (capture) begin
            case (state_q)
                RUN:     state_d = redir ? SQUASH : RUN;
                SQUASH:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.mem_valid      <= 1'b0;
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_read   <= 1'b0;
            bus.mem_mem_write  <= 1'b0;
            bus.mem_mem_to_reg <= 1'b0;
            bus.mem_alu_result <= 32'h0;
            bus.mem_store_data <= 32'h0;
            bus.mem_write_reg  <= 5'd0;
        end else if (capture) begin
            bus.mem_valid      <= v;
            bus.mem_reg_write  <= v && bus.ex_reg_write && bus.WriteEnable && !bus.OverFlow;
            bus.mem_mem_read   <= v && bus.ex_mem_read && !trap;
            bus.mem_mem_write  <= v && bus.ex_mem_write && !trap;
            bus.mem_mem_to_reg <= v && bus.ex_mem_to_reg && !trap;
            bus.mem_alu_result <= bus.ALUResult;
            bus.mem_store_data <= bus.ex_store_data;
            bus.mem_write_reg  <= bus.ex_write_reg;
        end
    end

    // The pulse self-clears the following edge even if MEM stalls.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.redirect_valid <= 1'b0;
            bus.flush_upstream <= 1'b0;
            bus.redirect_pc    <= 32'h0;
        end else begin
            bus.redirect_valid <= capture && redir;
            bus.flush_upstream <= capture && redir;
            if (capture && redir) bus.redirect_pc <= redir_target;
        end
    end

`ifdef EX_MEM_OVF_TRAP_EN
    // A trap arriving with the ack wins over the clear and recaptures EPC.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.exc_pending <= 1'b0;
            bus.epc         <= 32'h0;
            bus.cause       <= 32'h0;
        end else if (capture && trap && (!bus.exc_pending || bus.exc_ack)) begin
            bus.exc_pending <= 1'b1;
            bus.epc         <= bus.ex_pc;
            bus.cause       <= 32'h0000_0030;
        end else if (bus.exc_ack) begin
            bus.exc_pending <= 1'b0;
        end
    end
`else
    assign bus.exc_pending = 1'b0;
    assign bus.epc         = 32'h0;
    assign bus.cause       = 32'h0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized self-checking bench for ex_mem_stage against a behavioural model
module tb_ex_mem_stage;
    localparam logic [31:0] VEC = 32'h8000_0180;
`ifdef EX_MEM_OVF_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    ex_mem_stage_if bus ();

    ex_mem_stage #(.EXC_VECTOR(VEC)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state: whether the next capture is a wrong-path bubble, plus expected outputs
    bit          m_squash;
    bit          e_valid, e_rw, e_rd, e_wr, e_m2r, e_redir, e_pend;
    logic [31:0] e_alu, e_sd, e_rpc, e_epc, e_cause;
    logic [4:0]  e_wreg;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_squash = 0;
        {e_valid, e_rw, e_rd, e_wr, e_m2r, e_redir, e_pend} = '0;
        e_alu = 0; e_sd = 0; e_rpc = 0; e_epc = 0; e_cause = 0; e_wreg = 0;
    endtask

    // what one rising edge does to the stage, stated from the stage's rules
    task automatic model_edge();
        bit live, ovf_trap, go;
        logic [31:0] tgt;
        e_redir = 0;
        if (!bus.mem_stall) begin
            live     = bus.ex_valid && !m_squash;
            ovf_trap = TRAP_ON && live && bus.OverFlow;
            e_valid  = live;
            e_rw     = live && bus.ex_reg_write && bus.WriteEnable && !bus.OverFlow;
            e_rd     = live && bus.ex_mem_read && !ovf_trap;
            e_wr     = live && bus.ex_mem_write && !ovf_trap;
            e_m2r    = live && bus.ex_mem_to_reg && !ovf_trap;
            e_alu    = bus.ALUResult;
            e_sd     = bus.ex_store_data;
            e_wreg   = bus.ex_write_reg;
            go = 1; tgt = 0;
            if (ovf_trap)                                 tgt = VEC;
            else if (live && bus.JrSel)                   tgt = bus.ALUResult;
            else if (live && bus.ex_is_branch && bus.Zero) tgt = bus.ex_branch_target;
            else                                          go = 0;
            if (go) begin e_redir = 1; e_rpc = tgt; end
            if (ovf_trap && (!e_pend || bus.exc_ack)) begin
                e_pend = 1; e_epc = bus.ex_pc; e_cause = 32'h30;
            end else if (bus.exc_ack) e_pend = 0;
            m_squash = m_squash ? 0 : go;
        end else if (TRAP_ON && bus.exc_ack) e_pend = 0;
    endtask

    task automatic check_all();
        check("ex_ready", bus.ex_ready, !bus.mem_stall);
        check("mem_valid", bus.mem_valid, e_valid);
        check("mem_reg_write", bus.mem_reg_write, e_rw);
        check("mem_mem_read", bus.mem_mem_read, e_rd);
        check("mem_mem_write", bus.mem_mem_write, e_wr);
        check("mem_mem_to_reg", bus.mem_mem_to_reg, e_m2r);
        check("mem_alu_result", bus.mem_alu_result, e_alu);
        check("mem_store_data", bus.mem_store_data, e_sd);
        check("mem_write_reg", bus.mem_write_reg, e_wreg);
        check("redirect_valid", bus.redirect_valid, e_redir);
        check("flush_upstream", bus.flush_upstream, e_redir);
        check("redirect_pc", bus.redirect_pc, e_rpc);
        check("exc_pending", bus.exc_pending, TRAP_ON ? e_pend : 1'b0);
        check("epc", bus.epc, TRAP_ON ? e_epc : 32'h0);
        check("cause", bus.cause, TRAP_ON ? e_cause : 32'h0);
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.ALUResult = 0; bus.Zero = 0; bus.WriteEnable = 1;
        bus.OverFlow = 0; bus.JrSel = 0; bus.ex_is_branch = 0; bus.ex_pc = 0;
        bus.ex_branch_target = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
        bus.ex_mem_write = 0; bus.ex_mem_to_reg = 0; bus.ex_write_reg = 0;
        bus.ex_store_data = 0; bus.mem_stall = 0; bus.exc_ack = 0;
    endtask

    task automatic alu_op(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd);
        idle();
        bus.ex_valid = 1; bus.ex_pc = pc; bus.ALUResult = res;
        bus.ex_write_reg = rd; bus.ex_reg_write = 1;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_all();
    endtask

    int pulses;

    initial begin
        idle();
        model_reset();
        #12;
        check_all();
        @(negedge Clk);
        Rst_n = 1;

        alu_op(32'h0040_0000, 32'h0000_0007, 5'd5);
        step();
        check("add_result", bus.mem_alu_result, 32'h7);
        check("add_wreg", bus.mem_write_reg, 32'd5);
        check("add_regwrite", bus.mem_reg_write, 32'd1);

        alu_op(32'h0040_0010, 32'h0, 5'd0);
        bus.ex_reg_write = 0; bus.ex_is_branch = 1; bus.Zero = 1;
        bus.ex_branch_target = 32'h0040_0040;
        step();
        check("br_redirect", bus.redirect_valid, 32'd1);
        check("br_target", bus.redirect_pc, 32'h0040_0040);
        alu_op(32'h0040_0014, 32'h11, 5'd3);
        step();
        check("br_bubble", bus.mem_valid, 32'd0);
        check("br_pulse_end", bus.redirect_valid, 32'd0);

        alu_op(32'h0040_0020, 32'h0040_1000, 5'd0);
        bus.JrSel = 1; bus.WriteEnable = 0;
        step();
        check("jr_target", bus.redirect_pc, 32'h0040_1000);
        check("jr_regwrite", bus.mem_reg_write, 32'd0);
        idle(); bus.ex_valid = 1;
        step();

        alu_op(32'h0040_0020, 32'h1234_5678, 5'd8);
        bus.OverFlow = 1;
        step();
        if (TRAP_ON) begin
            check("ovf_target", bus.redirect_pc, VEC);
            check("ovf_epc", bus.epc, 32'h0040_0020);
            check("ovf_cause", bus.cause, 32'h30);
            check("ovf_pending", bus.exc_pending, 32'd1);
            idle(); bus.ex_valid = 1;
            step();
            alu_op(32'h0040_0030, 32'h1, 5'd9);
            bus.OverFlow = 1;
            step();
            check("ovf2_epc", bus.epc, 32'h0040_0020);
            check("ovf2_redirect", bus.redirect_valid, 32'd1);
            idle(); bus.exc_ack = 1;
            step();
            check("ack_clear", bus.exc_pending, 32'd0);
        end else begin
            check("ovf_noredir", bus.redirect_valid, 32'd0);
            check("ovf_valid", bus.mem_valid, 32'd1);
            check("ovf_regwrite", bus.mem_reg_write, 32'd0);
        end

        // stalled taken branch: one pulse, one bubble
        alu_op(32'h0040_0100, 32'h0, 5'd0);
        bus.ex_is_branch = 1; bus.Zero = 1; bus.ex_branch_target = 32'h0040_0200;
        bus.mem_stall = 1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(bus.redirect_valid);
        end
        bus.mem_stall = 0;
        step();
        pulses += int'(bus.redirect_valid);
        alu_op(32'h0040_0104, 32'h22, 5'd4);
        bus.mem_stall = 1;
        step();
        pulses += int'(bus.redirect_valid);
        bus.mem_stall = 0;
        step();
        pulses += int'(bus.redirect_valid);
        check("stall_bubble", bus.mem_valid, 32'd0);
        step();
        pulses += int'(bus.redirect_valid);
        check("stall_after_valid", bus.mem_valid, 32'd1);
        check("stall_one_pulse", pulses, 32'd1);

        // reset while in SQUASH
        alu_op(32'h0040_0300, 32'h0, 5'd0);
        bus.ex_is_branch = 1; bus.Zero = 1; bus.ex_branch_target = 32'h0040_0400;
        step();
        #2 Rst_n = 0;
        #1;
        model_reset();
        check("rst_redirect", bus.redirect_valid, 32'd0);
        check("rst_pc", bus.redirect_pc, 32'd0);
        check("rst_valid", bus.mem_valid, 32'd0);
        check_all();
        @(negedge Clk);
        Rst_n = 1;
        alu_op(32'h0040_0304, 32'h33, 5'd6);
        step();
        check("post_rst_valid", bus.mem_valid, 32'd1);

        for (int i = 0; i < 1500; i++) begin
            idle();
            bus.ex_valid         = ($urandom_range(0, 3) != 0);
            bus.ALUResult        = $urandom();
            bus.Zero             = $urandom_range(0, 1);
            bus.WriteEnable      = ($urandom_range(0, 3) != 0);
            bus.OverFlow         = ($urandom_range(0, 9) == 0);
            bus.JrSel            = ($urandom_range(0, 9) == 0);
            bus.ex_is_branch     = ($urandom_range(0, 4) == 0);
            bus.ex_pc            = $urandom();
            bus.ex_branch_target = $urandom();
            bus.ex_reg_write     = $urandom_range(0, 1);
            bus.ex_mem_read      = $urandom_range(0, 1);
            bus.ex_mem_write     = $urandom_range(0, 1);
            bus.ex_mem_to_reg    = $urandom_range(0, 1);
            bus.ex_write_reg     = 5'($urandom());
            bus.ex_store_data    = $urandom();
            bus.mem_stall        = ($urandom_range(0, 3) == 0);
            bus.exc_ack          = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
